// File: rtl/mem_cell_array.sv
`default_nettype none
// mem_cell_array: DEPTH x WIDTH synchronous store with a one-hot select, a valid/ready request
// channel and one registered response slot; after reset it sweeps INIT_VALUE into every word.
module mem_cell_array #(
  parameter int               WIDTH      = 8,
  parameter int               DEPTH      = 8,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_rw,
  input  logic [DEPTH-1:0] req_sel,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_err,
  output logic             busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t           state;
  logic [AW-1:0]    cp;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    sel_idx;
  logic             sel_valid;
  logic             accept;

  always_comb begin
    sel_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (req_sel[k]) sel_idx = AW'(k);
    end
  end

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  assign sel_valid = (req_sel != '0) && ((req_sel & (req_sel - DEPTH'(1))) == '0);
  assign req_ready = (state == RUN) && (!resp_valid || resp_ready);
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[cp] <= INIT_VALUE;
      end else if (accept && req_rw && sel_valid) begin
        mem[sel_idx] <= req_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CLEAR;
      cp         <= '0;
      busy       <= 1'b1;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          cp <= cp + AW'(1);
          if (cp == AW'(DEPTH - 1)) begin
            state <= RUN;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          // Valid-select writes are silent; every other accepted request fills the slot.
          if (accept && (!req_rw || !sel_valid)) begin
            resp_valid <= 1'b1;
            resp_data  <= (sel_valid && !req_rw) ? mem[sel_idx] : '0;
            resp_err   <= !sel_valid;
          end else if (resp_valid && resp_ready) begin
            resp_valid <= 1'b0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule
`default_nettype wire
